// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LS-queue and instruction-fetch requests onto a byte-wide RAM with 1-cycle read latency.
// Optional feature MEM_CTRL_IO_STALL_EN: stores into the I/O region wait in IDLE while in_io_full_i is high.
module mem_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ena_i,
    input  logic                  in_rollback_i,
    input  logic                  in_data_ena_i,
    input  logic                  in_data_iswrite_i,
    input  logic [2:0]            in_data_size_i,
    input  logic [ADDR_WIDTH-1:0] in_data_addr_i,
    input  logic [31:0]           in_data_write_data_i,
    output logic                  out_data_ready_o,
    output logic [31:0]           out_data_read_data_o,
    input  logic                  in_fetch_ena_i,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr_i,
    output logic                  out_fetch_ready_o,
    output logic [31:0]           out_fetch_inst_o,
    input  logic [7:0]            in_ram_data_i,
    output logic [ADDR_WIDTH-1:0] out_ram_addr_o,
    output logic [7:0]            out_ram_data_o,
    output logic                  out_ram_wr_o,
    input  logic                  in_io_full_i,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [2:0] size_to_n(input logic [2:0] size);
        case (size)
            3'd1:    size_to_n = 3'd1;
            3'd2:    size_to_n = 3'd2;
            default: size_to_n = 3'd4;
        endcase
    endfunction

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  cur_fetch_q, cur_fetch_d;
    logic [2:0]            cur_n_q, cur_n_d;
    logic [31:0]           cur_wdata_q, cur_wdata_d;
    logic [31:0]           buf_q, buf_d;
    logic                  dpend_q, dpend_d;
    logic                  dwr_q, dwr_d;
    logic [2:0]            dn_q, dn_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [31:0]           dwdata_q, dwdata_d;
    logic                  fpend_q, fpend_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_data_q, ram_data_d;
    logic                  ram_wr_q, ram_wr_d;
    logic                  dready_q, dready_d;
    logic                  fready_q, fready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           finst_q, finst_d;

    logic                  d_valid, d_wr, d_stall, f_valid;
    logic [2:0]            d_n;
    logic [ADDR_WIDTH-1:0] d_addr, f_addr;
    logic [31:0]           d_wdata;
    logic [2:0]            cnt_m1, cnt_p1;
    logic [4:0]            rd_sel, wr_sel;

    // A pulse in this cycle takes precedence over the latch so it can start immediately.
    always_comb begin
        d_wr    = in_data_ena_i ? in_data_iswrite_i : dwr_q;
        d_n     = in_data_ena_i ? size_to_n(in_data_size_i) : dn_q;
        d_addr  = in_data_ena_i ? in_data_addr_i : daddr_q;
        d_wdata = in_data_ena_i ? in_data_write_data_i : dwdata_q;
        d_valid = in_data_ena_i ? (in_data_iswrite_i || !in_rollback_i)
                                : (dpend_q && (dwr_q || !in_rollback_i));
        f_valid = (in_fetch_ena_i || fpend_q) && !in_rollback_i;
        f_addr  = in_fetch_ena_i ? in_fetch_addr_i : faddr_q;
    end

`ifdef MEM_CTRL_IO_STALL_EN
    assign d_stall = d_wr && (d_addr >= IO_BASE) && in_io_full_i;
`else
    logic unused_io;
    assign unused_io = ^{in_io_full_i, IO_BASE};
    assign d_stall   = 1'b0;
`endif

    always_comb begin
        dpend_d  = dpend_q;
        dwr_d    = dwr_q;
        dn_d     = dn_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        fpend_d  = fpend_q;
        faddr_d  = faddr_q;
        if (state_q == S_DONE) begin
            if (cur_fetch_q) fpend_d = 1'b0;
            else             dpend_d = 1'b0;
        end
        // Stores are already committed, so rollback only discards loads and fetches.
        if (in_rollback_i) begin
            fpend_d = 1'b0;
            if (!dwr_q) dpend_d = 1'b0;
        end
        if (in_data_ena_i && (in_data_iswrite_i || !in_rollback_i)) begin
            dpend_d  = 1'b1;
            dwr_d    = in_data_iswrite_i;
            dn_d     = size_to_n(in_data_size_i);
            daddr_d  = in_data_addr_i;
            dwdata_d = in_data_write_data_i;
        end
        if (in_fetch_ena_i && !in_rollback_i) begin
            fpend_d = 1'b1;
            faddr_d = in_fetch_addr_i;
        end
    end

    assign cnt_m1 = cnt_q - 3'd1;
    assign cnt_p1 = cnt_q + 3'd1;
    assign rd_sel = {cnt_m1[1:0], 3'b000};
    assign wr_sel = {cnt_p1[1:0], 3'b000};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_fetch_d = cur_fetch_q;
        cur_n_d     = cur_n_q;
        cur_wdata_d = cur_wdata_q;
        buf_d       = buf_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_wr_d    = 1'b0;
        dready_d    = 1'b0;
        fready_d    = 1'b0;
        rdata_d     = rdata_q;
        finst_d     = finst_q;
        case (state_q)
            S_IDLE: begin
                if (d_valid && !d_stall) begin
                    cur_fetch_d = 1'b0;
                    cur_n_d     = d_n;
                    cur_wdata_d = d_wdata;
                    buf_d       = 32'd0;
                    cnt_d       = 3'd0;
                    ram_addr_d  = d_addr;
                    if (d_wr) begin
                        state_d    = S_WRITE;
                        ram_wr_d   = 1'b1;
                        ram_data_d = d_wdata[7:0];
                    end else begin
                        state_d = S_READ;
                    end
                end else if (f_valid) begin
                    cur_fetch_d = 1'b1;
                    cur_n_d     = 3'd4;
                    buf_d       = 32'd0;
                    cnt_d       = 3'd0;
                    ram_addr_d  = f_addr;
                    state_d     = S_READ;
                end
            end
            // cnt_q is the byte whose address is on the bus; the previous byte arrives now.
            S_READ: begin
                if (in_rollback_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (cnt_q != 3'd0) buf_d[rd_sel +: 8] = in_ram_data_i;
                    cnt_d = cnt_p1;
                    if (cnt_p1 < cur_n_q) ram_addr_d = ram_addr_q + 1'b1;
                    if (cnt_q == cur_n_q) begin
                        state_d = S_DONE;
                        if (cur_fetch_q) begin
                            fready_d = 1'b1;
                            finst_d  = buf_d;
                        end else begin
                            dready_d = 1'b1;
                            rdata_d  = buf_d;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == cur_n_q - 3'd1) begin
                    state_d  = S_DONE;
                    dready_d = 1'b1;
                    rdata_d  = 32'd0;
                end else begin
                    cnt_d      = cnt_p1;
                    ram_addr_d = ram_addr_q + 1'b1;
                    ram_wr_d   = 1'b1;
                    ram_data_d = cur_wdata_q[wr_sel +: 8];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            cur_fetch_q <= 1'b0;
            cur_n_q     <= 3'd0;
            cur_wdata_q <= 32'd0;
            buf_q       <= 32'd0;
            dpend_q     <= 1'b0;
            dwr_q       <= 1'b0;
            dn_q        <= 3'd0;
            daddr_q     <= '0;
            dwdata_q    <= 32'd0;
            fpend_q     <= 1'b0;
            faddr_q     <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            dready_q    <= 1'b0;
            fready_q    <= 1'b0;
            rdata_q     <= 32'd0;
            finst_q     <= 32'd0;
        end else if (ena_i) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_fetch_q <= cur_fetch_d;
            cur_n_q     <= cur_n_d;
            cur_wdata_q <= cur_wdata_d;
            buf_q       <= buf_d;
            dpend_q     <= dpend_d;
            dwr_q       <= dwr_d;
            dn_q        <= dn_d;
            daddr_q     <= daddr_d;
            dwdata_q    <= dwdata_d;
            fpend_q     <= fpend_d;
            faddr_q     <= faddr_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_wr_q    <= ram_wr_d;
            dready_q    <= dready_d;
            fready_q    <= fready_d;
            rdata_q     <= rdata_d;
            finst_q     <= finst_d;
        end
    end

    assign out_data_ready_o     = dready_q;
    assign out_data_read_data_o = rdata_q;
    assign out_fetch_ready_o    = fready_q;
    assign out_fetch_inst_o     = finst_q;
    assign out_ram_addr_o       = ram_addr_q;
    assign out_ram_data_o       = ram_data_q;
    assign out_ram_wr_o         = ram_wr_q && ena_i;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte RAM, a request-level memory model and one compare process.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, ena, rollback;
  logic        d_ena, d_iswrite;
  logic [2:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        f_ena;
  logic [31:0] f_addr;
  logic        f_ready;
  logic [31:0] f_inst;
  logic [7:0]  ram_rd;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_wr;
  logic        io_full;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int d_cnt = 0, f_cnt = 0, d_last = 0, f_last = 0, last_wr_cyc = 0;
  int p, sd, sf;

  logic [39:0] exp_wr_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] exp_f_q[$];
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  shadow [logic [31:0]];

  mem_ctrl dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .in_rollback_i(rollback),
    .in_data_ena_i(d_ena), .in_data_iswrite_i(d_iswrite), .in_data_size_i(d_size),
    .in_data_addr_i(d_addr), .in_data_write_data_i(d_wdata),
    .out_data_ready_o(d_ready), .out_data_read_data_o(d_rdata),
    .in_fetch_ena_i(f_ena), .in_fetch_addr_i(f_addr),
    .out_fetch_ready_o(f_ready), .out_fetch_inst_o(f_inst),
    .in_ram_data_i(ram_rd), .out_ram_addr_o(ram_addr), .out_ram_data_o(ram_wdata),
    .out_ram_wr_o(ram_wr), .in_io_full_i(io_full), .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] sh_byte(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_byte(a);
  endfunction

  // byte RAM, one-cycle read latency, stalls together with the controller
  always @(posedge clk) begin
    if (ena) begin
      ram_rd <= ram_byte(ram_addr);
      if (ram_wr) ram[ram_addr] = ram_wdata;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      if (ram_wr) begin
        vectors++;
        last_wr_cyc = cyc;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL ram_write: unexpected write addr=%h data=%h", ram_addr, ram_wdata);
        end else begin
          logic [39:0] e;
          e = exp_wr_q.pop_front();
          if ({ram_addr, ram_wdata} !== e) begin
            miscompares++;
            $display("FAIL ram_write: got addr=%h data=%h want addr=%h data=%h", ram_addr, ram_wdata, e[39:8], e[7:0]);
          end
        end
      end
      if (d_ready) begin
        vectors++;
        d_cnt++;
        d_last = cyc;
        if (exp_d_q.size() == 0) begin
          miscompares++;
          $display("FAIL data_ready: unexpected ready, read_data=%h", d_rdata);
        end else begin
          logic [31:0] e;
          e = exp_d_q.pop_front();
          if (d_rdata !== e) begin
            miscompares++;
            $display("FAIL data_value: got %h want %h", d_rdata, e);
          end
        end
      end
      if (f_ready) begin
        vectors++;
        f_cnt++;
        f_last = cyc;
        if (exp_f_q.size() == 0) begin
          miscompares++;
          $display("FAIL fetch_ready: unexpected ready, inst=%h", f_inst);
        end else begin
          logic [31:0] e;
          e = exp_f_q.pop_front();
          if (f_inst !== e) begin
            miscompares++;
            $display("FAIL fetch_value: got %h want %h", f_inst, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic drive_data(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit push, input int nwr);
    int n;
    logic [31:0] v;
    n = (size == 3'd1) ? 1 : (size == 3'd2) ? 2 : 4;
    d_ena = 1'b1; d_iswrite = wr; d_size = size; d_addr = addr; d_wdata = wdata;
    if (wr) begin
      for (int k = 0; k < n && k < nwr; k++) begin
        exp_wr_q.push_back({addr + 32'(k), wdata[8*k +: 8]});
        shadow[addr + 32'(k)] = wdata[8*k +: 8];
      end
      if (push) exp_d_q.push_back(32'd0);
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = sh_byte(addr + 32'(k));
      if (push) exp_d_q.push_back(v);
    end
  endtask

  task automatic drive_fetch(input logic [31:0] addr, input bit push);
    logic [31:0] v;
    f_ena = 1'b1; f_addr = addr;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = sh_byte(addr + 32'(k));
    if (push) exp_f_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    d_ena = 1'b0; f_ena = 1'b0; rollback = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready(input bit fetch, input int start, input int pc, input int lat, input string name);
    int n;
    n = 0;
    while (((fetch ? f_cnt : d_cnt) == start) && n < 80) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if ((fetch ? f_cnt : d_cnt) == start) begin
      miscompares++;
      $display("FAIL %s: no ready within 80 cycles, want latency %0d", name, lat);
    end else if ((fetch ? f_last : d_last) - pc != lat) begin
      miscompares++;
      $display("FAIL %s: latency got %0d want %0d", name, (fetch ? f_last : d_last) - pc, lat);
    end
  endtask

  task automatic expect_none(input bit fetch, input int start, input int ncyc, input string name);
    ticks(ncyc);
    chk(name, 32'((fetch ? f_cnt : d_cnt) - start), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; rollback = 1'b0; io_full = 1'b0;
    d_ena = 1'b0; d_iswrite = 1'b0; d_size = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
    f_ena = 1'b0; f_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_read_data", d_rdata, 32'd0);
    chk("rst_fetch_ready", {31'd0, f_ready}, 32'd0);
    chk("rst_fetch_inst", f_inst, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_data", {24'd0, ram_wdata}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // store word, then byte / half / word loads of it
    sd = d_cnt; p = cyc; drive_data(1'b1, 3'd4, 32'h100, 32'hDEADBEEF, 1'b1, 4); tick();
    wait_ready(1'b0, sd, p, 5, "sw_latency");
    chk("sw_ram_bytes", {ram_byte(32'h103), ram_byte(32'h102), ram_byte(32'h101), ram_byte(32'h100)}, 32'hDEADBEEF);
    sd = d_cnt; p = cyc; drive_data(1'b0, 3'd1, 32'h103, 32'd0, 1'b1, 0); tick();
    wait_ready(1'b0, sd, p, 3, "lb_latency");
    chk("lb_value", d_rdata, 32'h000000DE);
    sd = d_cnt; p = cyc; drive_data(1'b0, 3'd2, 32'h102, 32'd0, 1'b1, 0); tick();
    wait_ready(1'b0, sd, p, 4, "lh_latency");
    chk("lh_value", d_rdata, 32'h0000DEAD);
    sd = d_cnt; p = cyc; drive_data(1'b0, 3'd4, 32'h100, 32'd0, 1'b1, 0); tick();
    wait_ready(1'b0, sd, p, 6, "lw_latency");
    chk("lw_value", d_rdata, 32'hDEADBEEF);

    // load and fetch in the same cycle: load first, fetch starts in the next IDLE cycle
    sd = d_cnt; sf = f_cnt; p = cyc;
    drive_data(1'b0, 3'd4, 32'h100, 32'd0, 1'b1, 0); drive_fetch(32'h0, 1'b1); tick();
    wait_ready(1'b0, sd, p, 6, "arb_load_first");
    wait_ready(1'b1, sf, p, 13, "arb_fetch_after");
    chk("arb_fetch_inst", f_inst, 32'h3F3E3D3C);
    sf = f_cnt; p = cyc; drive_fetch(32'h4, 1'b1); tick();
    wait_ready(1'b1, sf, p, 6, "fetch_latency");
    chk("fetch_inst", f_inst, 32'h3B3A3938);

    // address wrap, out-of-range size treated as 4 bytes
    sd = d_cnt; p = cyc; drive_data(1'b1, 3'd3, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b1, 4); tick();
    wait_ready(1'b0, sd, p, 5, "wrap_sw_latency");
    sd = d_cnt; p = cyc; drive_data(1'b0, 3'd0, 32'hFFFFFFFE, 32'd0, 1'b1, 0); tick();
    wait_ready(1'b0, sd, p, 6, "wrap_lw_latency");
    chk("wrap_lw_value", d_rdata, 32'hCAFEF00D);
    sd = d_cnt; p = cyc; drive_data(1'b0, 3'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 0); tick();
    wait_ready(1'b0, sd, p, 3, "wrap_lb_latency");
    chk("wrap_lb_value", d_rdata, 32'h000000F0);
    sd = d_cnt; p = cyc; drive_data(1'b0, 3'd2, 32'hFFFFFFFF, 32'd0, 1'b1, 0); tick();
    wait_ready(1'b0, sd, p, 4, "wrap_lh_latency");
    chk("wrap_lh_value", d_rdata, 32'h0000FEF0);

    // rollback: load aborted, store completes, fetch pulse dropped
    sd = d_cnt; drive_data(1'b0, 3'd4, 32'h100, 32'd0, 1'b0, 0); tick(); tick();
    rollback = 1'b1; tick();
    expect_none(1'b0, sd, 15, "rb_load_no_ready");
    sd = d_cnt; p = cyc; drive_data(1'b1, 3'd4, 32'h400, 32'h12345678, 1'b1, 4); tick(); tick();
    rollback = 1'b1; tick();
    wait_ready(1'b0, sd, p, 5, "rb_store_completes");
    sf = f_cnt; drive_fetch(32'h8, 1'b0); rollback = 1'b1; tick();
    expect_none(1'b1, sf, 12, "rb_fetch_dropped");

    // ena low mid-access holds everything
    sd = d_cnt; p = cyc; drive_data(1'b1, 3'd4, 32'h200, 32'h0BADF00D, 1'b1, 4); tick(); tick();
    ena = 1'b0; ticks(3); ena = 1'b1;
    wait_ready(1'b0, sd, p, 8, "ena_store_latency");
    sd = d_cnt; p = cyc; drive_data(1'b0, 3'd4, 32'h200, 32'd0, 1'b1, 0); tick(); tick();
    ena = 1'b0; ticks(2); ena = 1'b1;
    wait_ready(1'b0, sd, p, 8, "ena_load_latency");
    chk("ena_load_value", d_rdata, 32'h0BADF00D);

    // reset two cycles into a store: two bytes written, nothing after
    sd = d_cnt; drive_data(1'b1, 3'd4, 32'h300, 32'h11223344, 1'b0, 2); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_mid_read_data", d_rdata, 32'd0);
    expect_none(1'b0, sd, 10, "rst_mid_no_ready");
    chk("rst_mid_bytes", {8'd0, ram_byte(32'h302), ram_byte(32'h301), ram_byte(32'h300)}, 32'h003D3344);

    // I/O-region store with the TX buffer full
    sd = d_cnt; p = cyc; io_full = 1'b1;
    drive_data(1'b1, 3'd1, 32'h30000, 32'h00000041, 1'b1, 1); tick();
`ifdef MEM_CTRL_IO_STALL_EN
    tick();
    sf = f_cnt; drive_fetch(32'h4, 1'b1); tick();
    ticks(7);
    io_full = 1'b0;
    wait_ready(1'b1, sf, p + 2, 6, "io_fetch_bypass");
    wait_ready(1'b0, sd, p, 12, "io_store_latency");
    chk("io_first_write_cycle", 32'(last_wr_cyc - p), 32'd11);
`else
    wait_ready(1'b0, sd, p, 2, "io_store_latency");
    chk("io_first_write_cycle", 32'(last_wr_cyc - p), 32'd1);
    io_full = 1'b0;
`endif
    ticks(3);

    chk("left_writes", 32'(exp_wr_q.size()), 32'd0);
    chk("left_data", 32'(exp_d_q.size()), 32'd0);
    chk("left_fetch", 32'(exp_f_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
